// File: rtl/muldiv_iter.sv
// Iterative RV64 M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/busy/done handshake and flush abort.
module muldiv_iter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              word_mode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] sext_half(input logic [DATA_W-1:0] x);
    return {{HALF_W{x[HALF_W-1]}}, x[HALF_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] zext_half(input logic [DATA_W-1:0] x);
    return {{HALF_W{1'b0}}, x[HALF_W-1:0]};
  endfunction

  state_t              state_r, state_s;
  logic                load_s;
  logic                busy_r, done_r;
  logic [DATA_W-1:0]   result_r;
  logic [2:0]          op_r;
  logic                word_r;
  logic                special_r;
  logic                neg_q_r, neg_rem_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   hi_r, lo_r, opb_r;

  logic                a_signed_s, b_signed_s;
  logic [DATA_W-1:0]   a_ext_s, b_ext_s;
  logic                a_neg_s, b_neg_s;
  logic [DATA_W-1:0]   mag_a_s, mag_b_s;
  logic [DATA_W-1:0]   min_s;
  logic                div_zero_s, div_ovf_s, special_s;
  logic [DATA_W-1:0]   spec_val_s;

  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W:0]     div_trial_s, div_diff_s;
  logic                div_ge_s;

  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   raw_s, fix_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand conditioning and special-case detection for the load edge
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    if (op[2]) begin
      a_signed_s = ~op[0];
      b_signed_s = ~op[0];
    end else if (word_mode) begin
      // Word multiply only keeps the low half, so signedness is irrelevant
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
    end else begin
      a_signed_s = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
      b_signed_s = (op[1:0] == 2'b01);
    end

    if (word_mode) begin
      a_ext_s = a_signed_s ? sext_half(operand_a) : zext_half(operand_a);
      b_ext_s = b_signed_s ? sext_half(operand_b) : zext_half(operand_b);
      min_s   = {{HALF_W{1'b1}}, 1'b1, {(HALF_W-1){1'b0}}};
    end else begin
      a_ext_s = operand_a;
      b_ext_s = operand_b;
      min_s   = {1'b1, {(DATA_W-1){1'b0}}};
    end

    a_neg_s = a_signed_s & a_ext_s[DATA_W-1];
    b_neg_s = b_signed_s & b_ext_s[DATA_W-1];
    mag_a_s = a_neg_s ? -a_ext_s : a_ext_s;
    mag_b_s = b_neg_s ? -b_ext_s : b_ext_s;

    div_zero_s = op[2] && (b_ext_s == {DATA_W{1'b0}});
    div_ovf_s  = op[2] && !op[0] && (a_ext_s == min_s) && (b_ext_s == {DATA_W{1'b1}});
    special_s  = div_zero_s || div_ovf_s;

    if (div_zero_s) begin
      spec_val_s = op[1] ? a_ext_s : {DATA_W{1'b1}};
    end else if (div_ovf_s) begin
      spec_val_s = op[1] ? {DATA_W{1'b0}} : a_ext_s;
    end else begin
      spec_val_s = {DATA_W{1'b0}};
    end
  end

  // Single-bit iteration step for both datapaths
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(DATA_W+1){1'b0}});
    div_trial_s = {hi_r, lo_r[DATA_W-1]};
    div_diff_s  = div_trial_s - {1'b0, opb_r};
    div_ge_s    = (div_trial_s >= {1'b0, opb_r});
  end

  // Sign correction and output selection performed in FIX
  always_comb begin
    // Word-mode products finish shifted up by the skipped half-width iterations
    prod_s = word_r ? ({hi_r, lo_r} >> HALF_W) : {hi_r, lo_r};
    prod_s = neg_q_r ? -prod_s : prod_s;
    if (special_r) begin
      raw_s = lo_r;
    end else if (op_r[2]) begin
      if (op_r[1]) begin
        raw_s = neg_rem_r ? -hi_r : hi_r;
      end else begin
        raw_s = neg_q_r ? -lo_r : lo_r;
      end
    end else if ((op_r[1:0] == 2'b00) || word_r) begin
      raw_s = prod_s[DATA_W-1:0];
    end else begin
      raw_s = prod_s[2*DATA_W-1:DATA_W];
    end
    fix_s = word_r ? sext_half(raw_s) : raw_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start && !flush) begin
          load_s  = 1'b1;
          state_s = special_s ? ST_FIX : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_CALC) || (state_s == ST_FIX);
      done_r  <= (state_s == ST_DONE);
      if ((state_r == ST_FIX) && (state_s == ST_DONE)) begin
        result_r <= fix_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  // Operand load and iterative datapath
  always_ff @(posedge clk) begin
    if (srst) begin
      op_r      <= 3'b000;
      word_r    <= 1'b0;
      special_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= {DATA_W{1'b0}};
      lo_r      <= {DATA_W{1'b0}};
      opb_r     <= {DATA_W{1'b0}};
    end else if (load_s) begin
      op_r      <= op;
      word_r    <= word_mode;
      special_r <= special_s;
      neg_q_r   <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      cnt_r     <= word_mode ? CNT_W'(HALF_W) : CNT_W'(DATA_W);
      hi_r      <= {DATA_W{1'b0}};
      if (special_s) begin
        lo_r  <= spec_val_s;
        opb_r <= {DATA_W{1'b0}};
      end else if (op[2]) begin
        // Dividend starts at the top so its MSB is consumed first
        lo_r  <= word_mode ? (mag_a_s << HALF_W) : mag_a_s;
        opb_r <= mag_b_s;
      end else begin
        lo_r  <= mag_b_s;
        opb_r <= mag_a_s;
      end
    end else if (state_r == ST_CALC) begin
      cnt_r <= cnt_r - CNT_W'(1);
      if (op_r[2]) begin
        hi_r <= div_ge_s ? div_diff_s[DATA_W-1:0] : div_trial_s[DATA_W-1:0];
        lo_r <= {lo_r[DATA_W-2:0], div_ge_s};
      end else begin
        hi_r <= mul_sum_s[DATA_W:1];
        lo_r <= {mul_sum_s[0], lo_r[DATA_W-1:1]};
      end
    end else begin
      cnt_r <= cnt_r;
      hi_r  <= hi_r;
      lo_r  <= lo_r;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors push expected results and
// completion cycles; a monitor pops and compares on every done pulse.
module tb_muldiv_iter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         srst, start, flush, word_mode;
  logic [2:0]   op;
  logic [W-1:0] operand_a, operand_b, result;
  logic         busy, done;

  muldiv_iter #(.DATA_W(W)) dut (
    .clk(clk), .srst(srst), .start(start), .op(op), .word_mode(word_mode),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    int           tag;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_res = '0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (!srst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done at cycle %0d, expected no done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("result_%0d", mon_e.tag), result, mon_e.res);
          check($sformatf("done_cycle_%0d", mon_e.tag), W'(cyc), W'(mon_e.due));
        end
      end
      if (prev_done) check("done_gap", W'(done), W'(1'b0));
    end
    prev_done <= done;
  end

  task automatic issue(input logic [2:0] o, input logic wm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r, input int lat, input int tag);
    exp_t e;
    op = o; word_mode = wm; operand_a = a; operand_b = b; start = 1'b1;
    e.res = r; e.due = cyc + lat; e.tag = tag;
    exp_q.push_back(e);
    last_res = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int tag);
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%0d: %0d results outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    srst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; word_mode = 1'b0;
    operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);
    srst = 1'b0;
    @(negedge clk);

    // Full-width multiply
    issue(MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 1);  drain(1);
    issue(MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66, 2);                    drain(2);
    issue(MULH,   1'b0, ONES, ONES, 64'd0, 66, 3);                                      drain(3);
    issue(MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 66, 4);                   drain(4);
    issue(MULHSU, 1'b0, 64'd2, ONES, 64'd1, 66, 5);                                     drain(5);
    // Full-width divide
    issue(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 6); drain(6);
    issue(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66, 7);                    drain(7);
    issue(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 8);                                   drain(8);
    issue(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 9);                                    drain(9);
    // Special cases
    issue(DIVU, 1'b0, 64'h1234, 64'd0, ONES, 2, 10);                                    drain(10);
    issue(REM,  1'b0, 64'h1234, 64'd0, 64'h1234, 2, 11);                                drain(11);
    issue(DIV,  1'b0, MINV, ONES, MINV, 2, 12);                                         drain(12);
    issue(REM,  1'b0, MINV, ONES, 64'd0, 2, 13);                                        drain(13);
    // Word mode
    issue(MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 14);          drain(14);
    issue(DIV,  1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, 15);          drain(15);
    issue(DIVU, 1'b1, 64'hFFFF_FFFF, 64'd0, ONES, 2, 16);                               drain(16);
    issue(REM,  1'b1, 64'hFFFF_FFF9, 64'd2, ONES, 34, 17);                              drain(17);

    // Flush in cycle 10, fresh start in cycle 11
    op = DIVU; word_mode = 1'b0; operand_a = 64'd500; operand_b = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    check("flush_result_kept", result, last_res);
    issue(DIVU, 1'b0, 64'd1000, 64'd9, 64'd111, 66, 18);                                drain(18);

    // start re-asserted while busy is ignored; start in DONE is accepted
    issue(MUL, 1'b0, 64'd5, 64'd6, 64'd30, 66, 19);
    check("busy_cycle1", W'(busy), W'(1'b1));
    op = DIV; operand_a = 64'd99; operand_b = 64'd3; start = 1'b1;
    repeat (65) @(negedge clk);
    check("done_cycle_busy", W'(busy), '0);
    issue(REMU, 1'b0, 64'd1000, 64'd9, 64'd1, 66, 20);                                  drain(20);

    // start together with flush in IDLE
    op = MUL; operand_a = 64'd3; operand_b = 64'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", W'(busy), '0);
    repeat (3) @(negedge clk);

    // Reset mid-CALC
    issue(MULHU, 1'b0, ONES, 64'd3, 64'd2, 66, 21);
    repeat (5) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    exp_q.delete();
    check("srst_busy", W'(busy), '0);
    check("srst_done", W'(done), '0);
    check("srst_result", result, '0);
    @(negedge clk);
    issue(MULHU, 1'b0, ONES, 64'd3, 64'd2, 66, 22);                                     drain(22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
